// File: rtl/aes_pkg.sv
// Shared definitions for the AES core: owner state, byte width and requester port indices.
// No timing of its own; types and constants only.
// No flow control of its own; used by the S-box arbiter and its neighbours.
package aes_pkg;

    localparam int SBOX_W = 8;

    // Requester port indices, also the encoding of the round-robin last-winner flag
    localparam logic PORT_KS = 1'b0;
    localparam logic PORT_RD = 1'b1;

    // Which requester currently holds the S-box for a burst
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

endpackage

// File: rtl/aes_sbox_arbiter.sv
// Shares one registered S-box between the key schedule (A) and the round datapath (B), burst-locked, round-robin on ties.
// Grant is combinational in the request cycle; the result returns with a per-port valid one cycle later.
// A requester that is not granted holds its byte and direction stable; the owner keeps the S-box while its access stays high.
module aes_sbox_arbiter
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ks_access_i,
    input  logic [SBOX_W-1:0] ks_data_i,
    input  logic              ks_decrypt_i,
    output logic              ks_grant_o,
    output logic              ks_valid_o,
    output logic [SBOX_W-1:0] ks_data_o,
    input  logic              rd_access_i,
    input  logic [SBOX_W-1:0] rd_data_i,
    input  logic              rd_decrypt_i,
    output logic              rd_grant_o,
    output logic              rd_valid_o,
    output logic [SBOX_W-1:0] rd_data_o,
    output logic              sbox_access_o,
    output logic [SBOX_W-1:0] sbox_data_o,
    output logic              sbox_decrypt_o,
    input  logic [SBOX_W-1:0] sbox_data_i
);

    owner_t owner;
    logic   rr_last;
    logic   ks_valid_q;
    logic   rd_valid_q;
    logic   lock_ks;
    logic   lock_rd;
    logic   win_ks;
    logic   win_rd;
    logic   arbitrating;

    // Lock to the current owner while it holds access; otherwise pick among requesters, ties going away from rr_last
    always_comb begin
        lock_ks     = (owner == OWN_A) && ks_access_i;
        lock_rd     = (owner == OWN_B) && rd_access_i;
        arbitrating = !(lock_ks || lock_rd);
        win_ks      = 1'b0;
        win_rd      = 1'b0;
        if (lock_ks) begin
            win_ks = 1'b1;
        end else if (lock_rd) begin
            win_rd = 1'b1;
        end else if (ks_access_i && rd_access_i) begin
            win_ks = (rr_last == PORT_RD);
            win_rd = (rr_last == PORT_KS);
        end else begin
            win_ks = ks_access_i;
            win_rd = rd_access_i;
        end
    end

    // Grants are forced low while reset is asserted so the S-box sees nothing during reset
    assign ks_grant_o = win_ks & reset;
    assign rd_grant_o = win_rd & reset;

    // Steer the granted port's byte and direction onto the S-box, zero when idle
    always_comb begin
        sbox_data_o    = '0;
        sbox_decrypt_o = 1'b0;
        if (ks_grant_o) begin
            sbox_data_o    = ks_data_i;
            sbox_decrypt_o = ks_decrypt_i;
        end else if (rd_grant_o) begin
            sbox_data_o    = rd_data_i;
            sbox_decrypt_o = rd_decrypt_i;
        end
    end

    assign sbox_access_o = ks_grant_o | rd_grant_o;

    // Owner follows the granted port; rr_last only moves on a fresh arbitration win, not while locked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= IDLE;
            rr_last <= PORT_RD;
        end else begin
            if (ks_grant_o) begin
                owner <= OWN_A;
            end else if (rd_grant_o) begin
                owner <= OWN_B;
            end else begin
                owner <= IDLE;
            end
            if (arbitrating && ks_grant_o) begin
                rr_last <= PORT_KS;
            end else if (arbitrating && rd_grant_o) begin
                rr_last <= PORT_RD;
            end
        end
    end

    // Delay each grant by the S-box register stage to mark which port the returning byte belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ks_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ks_valid_q <= ks_grant_o;
            rd_valid_q <= rd_grant_o;
        end
    end

    assign ks_valid_o = ks_valid_q;
    assign rd_valid_o = rd_valid_q;
    assign ks_data_o  = ks_valid_q ? sbox_data_i : '0;
    assign rd_data_o  = rd_valid_q ? sbox_data_i : '0;

endmodule
